// File: rtl/msrv32_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_load_store_unit
// Brief    : Stage-3 data-memory access unit: request/ack data-bus handshake,
//            pipeline stall, load alignment/extension, misaligned and bus-error
//            flags. Optional WAIT timeout enabled by defining LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module msrv32_load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        mem_req_in,
    input  logic        mem_wr_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    output logic        dbus_req_out,
    output logic        dbus_we_out,
    output logic [31:0] dbus_addr_out,
    output logic [31:0] dbus_wdata_out,
    output logic [3:0]  dbus_wstrb_out,
    input  logic        dbus_ack_in,
    input  logic        dbus_err_in,
    input  logic [31:0] dbus_rdata_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_wr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;

    logic        w_misaligned;
    logic        w_start;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    always_comb begin
        w_misaligned = 1'b0;
        case (load_size_in)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = addr_in[0];
            default: w_misaligned = |addr_in[1:0];
        endcase
    end

    assign w_start = (r_state == S_IDLE) && mem_req_in && !w_misaligned;

    // Gated by reset so an asserted reset releases the pipeline immediately.
    assign stall_out = !reset_in && (w_start || (r_state == S_WAIT));

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = store_data_in;
        case (load_size_in)
            2'b00: begin
                w_wstrb = 4'b0001 << addr_in[1:0];
                w_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                w_wstrb = addr_in[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data_in[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = store_data_in;
            end
        endcase
        if (!mem_wr_in) begin
            w_wstrb = 4'b0000;
        end
    end

    always_comb begin
        w_byte = dbus_rdata_in[7:0];
        case (r_lane)
            2'd0:    w_byte = dbus_rdata_in[7:0];
            2'd1:    w_byte = dbus_rdata_in[15:8];
            2'd2:    w_byte = dbus_rdata_in[23:16];
            default: w_byte = dbus_rdata_in[31:24];
        endcase
        w_half = r_lane[1] ? dbus_rdata_in[31:16] : dbus_rdata_in[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            2'b01:   w_load_data = {{16{w_half[15] & ~r_unsigned}}, w_half};
            default: w_load_data = dbus_rdata_in;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMR_W-1:0] r_timer;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_timer <= '0;
        end else if (w_start) begin
            r_timer <= '0;
        end else if ((r_state == S_WAIT) && !dbus_ack_in) begin
            r_timer <= r_timer + c_TMR_W'(1);
        end
    end

    // Fires in the last allowed WAIT cycle; a same-cycle ack wins.
    assign w_timeout = (r_state == S_WAIT) && !dbus_ack_in &&
                       (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state        <= S_IDLE;
            r_wr           <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_lane         <= 2'b00;
            dbus_req_out   <= 1'b0;
            dbus_we_out    <= 1'b0;
            dbus_addr_out  <= 32'd0;
            dbus_wdata_out <= 32'd0;
            dbus_wstrb_out <= 4'b0000;
            load_data_out  <= 32'd0;
            load_valid_out <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req_in && w_misaligned) begin
                        misaligned_out <= 1'b1;
                    end else if (w_start) begin
                        dbus_req_out   <= 1'b1;
                        dbus_we_out    <= mem_wr_in;
                        dbus_addr_out  <= {addr_in[31:2], 2'b00};
                        dbus_wdata_out <= w_wdata;
                        dbus_wstrb_out <= w_wstrb;
                        r_wr           <= mem_wr_in;
                        r_size         <= load_size_in;
                        r_unsigned     <= load_unsigned_in;
                        r_lane         <= addr_in[1:0];
                        r_state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dbus_ack_in) begin
                        dbus_req_out <= 1'b0;
                        r_state      <= S_DONE;
                        if (dbus_err_in) begin
                            bus_error_out <= 1'b1;
                            load_data_out <= 32'd0;
                        end else if (!r_wr) begin
                            load_data_out  <= w_load_data;
                            load_valid_out <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        dbus_req_out  <= 1'b0;
                        bus_error_out <= 1'b1;
                        load_data_out <= 32'd0;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_msrv32_load_store_unit
// Brief    : Scoreboard bench for msrv32_load_store_unit with a byte-level
//            reference model; timeout cases only when LSU_TIMEOUT_EN is set.
// Revision : 1.0
// ============================================================================
module tb_msrv32_load_store_unit;

    localparam int c_TO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam int c_LIMIT = c_TO;
`else
    localparam int c_LIMIT = 1 << 30;
`endif

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        mem_req_in, mem_wr_in, load_unsigned_in;
    logic [31:0] addr_in, store_data_in;
    logic [1:0]  load_size_in;
    logic        dbus_req_out, dbus_we_out;
    logic [31:0] dbus_addr_out, dbus_wdata_out;
    logic [3:0]  dbus_wstrb_out;
    logic        dbus_ack_in, dbus_err_in;
    logic [31:0] dbus_rdata_in;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out, misaligned_out, bus_error_out;

    msrv32_load_store_unit #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .mem_req_in(mem_req_in), .mem_wr_in(mem_wr_in),
        .addr_in(addr_in), .store_data_in(store_data_in),
        .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .dbus_req_out(dbus_req_out), .dbus_we_out(dbus_we_out),
        .dbus_addr_out(dbus_addr_out), .dbus_wdata_out(dbus_wdata_out),
        .dbus_wstrb_out(dbus_wstrb_out), .dbus_ack_in(dbus_ack_in),
        .dbus_err_in(dbus_err_in), .dbus_rdata_in(dbus_rdata_in),
        .stall_out(stall_out), .load_data_out(load_data_out),
        .load_valid_out(load_valid_out), .misaligned_out(misaligned_out),
        .bus_error_out(bus_error_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic [2:0]  flags;   // {load_valid, bus_error, misaligned}
        logic        wr;
        logic [31:0] data;
        int          at;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=output-event required=none (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a request or a pulse.
    req_t  cur;
    logic  prev_req = 1'b0;
    always @(negedge clk_in) begin
        if (reset_in) begin
            prev_req = 1'b0;
        end else begin
            if (dbus_req_out && !prev_req) begin
                if (req_q.size() == 0) unexpected("req_unexpected");
                else cur = req_q.pop_front();
            end
            if (dbus_req_out) begin
                check("req_fields", {dbus_we_out, dbus_addr_out, dbus_wstrb_out},
                      {cur.we, cur.addr, cur.wstrb});
                if (cur.we) check("req_wdata", dbus_wdata_out, cur.wdata);
            end
            prev_req = dbus_req_out;
            if (load_valid_out || bus_error_out || misaligned_out) begin
                if (resp_q.size() == 0) begin
                    unexpected("pulse_unexpected");
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    check("pulse_flags", {load_valid_out, bus_error_out, misaligned_out}, e.flags);
                    check("pulse_cycle", cyc, e.at);
                    if (e.flags[2] || (e.flags[1] && !e.wr))
                        check("load_data", load_data_out, e.data);
                end
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                               input int nb, input bit uns);
        longint one = 1;
        longint v;
        v = longint'(rdata >> (8 * off)) & ((one << (8 * nb)) - 1);
        if (!uns && nb < 4 && v >= (one << (8 * nb - 1))) v = v - (one << (8 * nb));
        return v[31:0];
    endfunction

    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size, input bit uns, input int d,
                         input bit err, input logic [31:0] rdata);
        int nb, off, c0, n_wait;
        bit mis, acked;
        req_t rq;
        resp_t rs;
        logic [31:0] dv;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        mis = (off % nb) != 0;
        acked  = d < c_LIMIT;
        n_wait = acked ? d + 1 : c_LIMIT;
        dv = data;
        @(negedge clk_in);
        mem_req_in = 1'b1; mem_wr_in = wr; addr_in = addr; store_data_in = data;
        load_size_in = size; load_unsigned_in = uns;
        c0 = cyc;
        if (!mis) begin
            rq.we = wr;
            rq.addr = {addr[31:2], 2'b00};
            rq.wstrb = 4'b0000;
            rq.wdata = 32'd0;
            for (int b = 0; b < 4; b++) begin
                rq.wdata[8*b +: 8] = dv[8*(b % nb) +: 8];
                if (wr && b >= off && b < off + nb) rq.wstrb[b] = 1'b1;
            end
            req_q.push_back(rq);
        end
        rs.wr = wr;
        rs.data = 32'd0;
        if (mis) begin
            rs.flags = 3'b001; rs.at = c0 + 1; resp_q.push_back(rs);
        end else if (!acked || err) begin
            rs.flags = 3'b010; rs.at = c0 + n_wait + 1; resp_q.push_back(rs);
        end else if (!wr) begin
            rs.flags = 3'b100; rs.at = c0 + n_wait + 1;
            rs.data = model_load(rdata, off, nb, uns);
            resp_q.push_back(rs);
        end
        #1 check("stall_detect", stall_out, !mis);
        @(posedge clk_in);
        #1 mem_req_in = 1'b0;
        if (mis) begin
            @(negedge clk_in);
            check("mis_no_req", {dbus_req_out, stall_out}, 2'b00);
        end else begin
            for (int k = 1; k <= n_wait; k++) begin
                @(negedge clk_in);
                check("wait_req_stall", {dbus_req_out, stall_out}, 2'b11);
                if (acked && k == n_wait) begin
                    dbus_ack_in = 1'b1; dbus_err_in = err; dbus_rdata_in = rdata;
                end else begin
                    dbus_ack_in = 1'b0; dbus_err_in = 1'($urandom); dbus_rdata_in = $urandom;
                end
            end
            @(negedge clk_in);
            dbus_ack_in = 1'b0; dbus_err_in = 1'b0;
            check("done_released", {dbus_req_out, stall_out}, 2'b00);
        end
    endtask

    initial begin
        reset_in = 1'b1;
        mem_req_in = 0; mem_wr_in = 0; addr_in = 0; store_data_in = 0;
        load_size_in = 0; load_unsigned_in = 0;
        dbus_ack_in = 0; dbus_err_in = 0; dbus_rdata_in = 0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_outputs", {dbus_req_out, dbus_we_out, dbus_addr_out, dbus_wdata_out,
              dbus_wstrb_out, stall_out, load_data_out, load_valid_out, misaligned_out,
              bus_error_out}, 0);
        #1 reset_in = 1'b0;

        do_op(0, 32'h100, 0, 2'b10, 0, 0, 0, 32'hDEADBEEF);
        do_op(0, 32'h103, 0, 2'b00, 0, 0, 0, 32'h80112233);
        do_op(0, 32'h103, 0, 2'b00, 1, 1, 0, 32'h80112233);
        do_op(1, 32'h202, 32'h0000ABCD, 2'b01, 0, 0, 0, 0);
        do_op(0, 32'h101, 0, 2'b10, 0, 0, 0, 0);
        do_op(0, 32'h302, 0, 2'b01, 0, 2, 0, 32'h8001_7FFF);
        do_op(0, 32'h303, 0, 2'b01, 0, 0, 0, 0);
        do_op(0, 32'h400, 0, 2'b10, 0, 3, 1, 32'h12345678);
        do_op(1, 32'h501, 32'h11223344, 2'b00, 0, 0, 0, 0);
        do_op(1, 32'h504, 32'h11223344, 2'b11, 0, 1, 1, 0);

        // Ack and error while idle must produce nothing.
        @(negedge clk_in);
        dbus_ack_in = 1'b1; dbus_err_in = 1'b1; dbus_rdata_in = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk_in);
        dbus_ack_in = 1'b0; dbus_err_in = 1'b0;
        check("idle_ack_ignored", {dbus_req_out, stall_out}, 2'b00);

`ifdef LSU_TIMEOUT_EN
        do_op(0, 32'h600, 0, 2'b10, 0, 100, 0, 0);
        do_op(0, 32'h604, 0, 2'b10, 0, c_TO - 1, 0, 32'hCAFEF00D);
        do_op(1, 32'h608, 32'h55, 2'b00, 0, c_TO, 0, 0);
`endif

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int dly;
            a = $urandom;
`ifdef LSU_TIMEOUT_EN
            dly = $urandom_range(0, 6);
`else
            dly = $urandom_range(0, 3);
`endif
            do_op(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), dly,
                  ($urandom_range(0, 7) == 0), $urandom);
        end

        // Reset in WAIT: request and stall must drop without a clock edge.
        @(negedge clk_in);
        mem_req_in = 1'b1; mem_wr_in = 1'b0; addr_in = 32'h700; load_size_in = 2'b10;
        req_q.push_back('{we: 1'b0, addr: 32'h700, wdata: 32'd0, wstrb: 4'b0000});
        @(posedge clk_in);
        #1 mem_req_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("wait_before_reset", {dbus_req_out, stall_out}, 2'b11);
        #2 reset_in = 1'b1;
        #1 check("reset_in_wait", {dbus_req_out, stall_out}, 2'b00);
        @(negedge clk_in);
        #1 reset_in = 1'b0;
        check("post_reset_idle", {dbus_req_out, load_valid_out, bus_error_out}, 3'b000);

        do_op(0, 32'h800, 0, 2'b01, 1, 0, 0, 32'h0000_F00F);
        repeat (4) @(negedge clk_in);
        check("req_queue_drained", req_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msrv32_load_store_unit.md
# msrv32_load_store_unit

Stage-3 data-memory access unit of the RV32I pipeline. Consumes the registered stage-2 outputs (effective address, store data, load size, load-unsigned flag) and runs a request/acknowledge transaction on the data bus. It stalls the pipeline until the access completes, aligns and extends load data for the writeback mux, and flags misaligned accesses and bus errors.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: WAIT-state cycle limit before abort (only with timeout feature).

Ports (reset reset_in, asynchronous, active-high; clock clk_in):
- clk_in  input  1  clock
- reset_in  input  1  asynchronous active-high reset
- mem_req_in  input  1  current stage-3 instruction is a load or store
- mem_wr_in  input  1  1 = store, 0 = load
- addr_in  input  32  effective address (stage-2 iadder register)
- store_data_in  input  32  rs2 value
- load_size_in  input  2  00 byte, 01 half, 10/11 word
- load_unsigned_in  input  1  zero-extend loads
- dbus_req_out  output  1  bus request
- dbus_we_out  output  1  bus write enable
- dbus_addr_out  output  32  word-aligned address {addr_in[31:2],2'b00}
- dbus_wdata_out  output  32  lane-replicated store data
- dbus_wstrb_out  output  4  byte strobes (0000 for loads)
- dbus_ack_in  input  1  transaction complete
- dbus_err_in  input  1  error, valid with dbus_ack_in
- dbus_rdata_in  input  32  read data, valid with dbus_ack_in
- stall_out  output  1  freeze stage-1/2 pipeline registers
- load_data_out  output  32  aligned, extended load result
- load_valid_out  output  1  load_data_out valid (1-cycle pulse)
- misaligned_out  output  1  misaligned access (1-cycle pulse)
- bus_error_out  output  1  bus error/timeout (1-cycle pulse)

## Operation
- States: IDLE, WAIT, DONE.
- Misaligned: half with addr_in[0]=1; word with addr_in[1:0]!=00. Byte never misaligned.
- IDLE, mem_req_in=1, misaligned: no bus access; misaligned_out=1 next cycle; stay IDLE.
- IDLE, mem_req_in=1, aligned: register dbus_* outputs; dbus_req_out=1 next cycle; -> WAIT.
- WAIT: dbus_req_out/we/addr/wdata/wstrb held stable until dbus_ack_in=1. On ack: dbus_req_out=0 next cycle; -> DONE; for loads without error load_data_out registered, load_valid_out=1; with dbus_err_in=1 bus_error_out=1, load_data_out=0.
- DONE: one cycle, mem_req_in ignored; -> IDLE.
- stall_out (combinational) = (IDLE & mem_req_in & ~misaligned) | WAIT.
- Store strobes: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111. wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load align: byte rdata lane addr[1:0], half lane addr[1]; sign-extend bit 7/15 unless load_unsigned_in.
- dbus_ack_in outside WAIT ignored.
- Reset values: all outputs 0, state IDLE. Reset mid-WAIT drops dbus_req_out immediately (asynchronous).

## Timing
- Access latency: detect cycle N, dbus_req_out cycle N+1, ack earliest N+1, load_valid_out/bus_error_out at N+2 (DONE), stall_out low from N+2.
- Minimum 3 cycles per memory instruction; each extra ack wait adds 1.
- misaligned_out at N+1; stall_out never asserted for misaligned access.
- Pulse outputs high exactly one cycle.

## Configuration
- LSU_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without ack; at TIMEOUT_CYCLES: dbus_req_out=0, bus_error_out=1, load_data_out=0, -> DONE. Ack in the same cycle as limit takes priority (normal completion).
- Undefined: no counter; WAIT holds indefinitely.

## Test plan
- Word load addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> req at N+1, load_data_out=0xDEADBEEF, load_valid_out at N+2, stall high N..N+1.
- Signed byte load addr 0x103, rdata 0x80112233 -> load_data_out=0xFFFFFF80; unsigned -> 0x00000080.
- Half store addr 0x202, data 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD, addr 0x200, we=1.
- Word load addr 0x101 -> misaligned_out pulse at N+1, no dbus_req_out, stall_out never high.
- Ack with dbus_err_in=1 after 3 wait cycles -> bus_error_out pulse, load_valid_out=0; reset asserted in WAIT -> dbus_req_out and stall_out 0 immediately.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> req dropped after 4 WAIT cycles, bus_error_out pulse, back to IDLE.
